alu_op_sequencer: RTL and testbench

- Front-end controller that sits in front of the combinational 9-bit ALU adder (ports a1, a2, cin, o).
- Accepts one 8-bit operation per request over a valid/ready handshake and maps it onto add-with-carry.
- Drives the ALU operand registers, waits a programmable settle time, then captures the sum and carry/zero flags.
- Returns the result over a second valid/ready handshake; maintains the processor carry flag for multi-byte ADC/SBC chains.

---
 rtl/alu_op_sequencer_pkg.sv | 19 +
 rtl/alu_op_sequencer_if.sv | 26 ++
 rtl/alu_op_sequencer_operand_map.sv | 20 ++
 rtl/alu_op_sequencer.sv | 73 +++++++
 tb/tb_alu_op_sequencer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// alu_seq_pkg: opcodes, FSM encoding and settle-time bounds shared by the ALU sequencer
package alu_seq_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;
  localparam logic [2:0] OP_INC = 3'd5;
  localparam logic [2:0] OP_DEC = 3'd6;
  localparam logic [2:0] OP_CLC = 3'd7;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W = $clog2(SETTLE_MAX + 1);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, ALU and response signals of the sequencer
interface alu_op_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [8:0] alu_a1;
  logic [8:0] alu_a2;
  logic       alu_cin;
  logic [8:0] alu_o;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       carry_flag;
  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_o, rsp_ready,
    output req_ready, alu_a1, alu_a2, alu_cin, rsp_valid, rsp_result, rsp_carry, rsp_zero, carry_flag
  );
  modport master (
    output req_valid, req_op, req_a, req_b, alu_o, rsp_ready,
    input  req_ready, alu_a1, alu_a2, alu_cin, rsp_valid, rsp_result, rsp_carry, rsp_zero, carry_flag
  );
endinterface

// File: rtl/alu_op_sequencer_operand_map.sv
// alu_operand_map: maps an opcode onto add-with-carry operands for the 9-bit ALU
module alu_operand_map
  import alu_seq_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_flag,
  output logic [8:0] a1,
  output logic [8:0] a2,
  output logic       cin
);
  logic inv_b;
  assign inv_b = op == OP_SUB || op == OP_SBC || op == OP_CMP;
  always_comb begin
    a1 = {1'b0, a};
    a2 = inv_b ? {1'b0, ~b} : op == OP_INC ? 9'h000 : op == OP_DEC ? 9'h0FF : {1'b0, b};
    cin = (op == OP_ADC || op == OP_SBC) ? carry_flag : (inv_b || op == OP_INC);
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front-end that drives the ALU adder, waits to settle,
// captures sum and flags, and keeps the architectural carry for ADC/SBC chains.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  alu_op_sequencer_if.slave bus
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2:0] op_q;
  logic [7:0] a_q;
  logic [8:0] a1_n, a2_n;
  logic cin_n, accept, capture, done, is_clc;
  alu_operand_map u_map (
    .op(bus.req_op), .a(bus.req_a), .b(bus.req_b), .carry_flag(bus.carry_flag),
    .a1(a1_n), .a2(a2_n), .cin(cin_n)
  );
  assign bus.req_ready = state == ST_IDLE && !rst;
  assign accept = bus.req_valid && bus.req_ready;
  assign is_clc = bus.req_op == OP_CLC;
  assign capture = state == ST_DRIVE && cnt == '0;
  assign done = state == ST_RESP && bus.rsp_valid && bus.rsp_ready;
  always_comb begin
    state_n = state;
    state_n = accept ? (is_clc ? ST_RESP : ST_DRIVE) : capture ? ST_RESP : done ? ST_IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_n;
  // counter starts at SETTLE_CYCLES so capture lands SETTLE_CYCLES+1 edges after accept
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt            <= '0;
      op_q           <= '0;
      a_q            <= '0;
      bus.alu_a1     <= '0;
      bus.alu_a2     <= '0;
      bus.alu_cin    <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_carry  <= 1'b0;
      bus.rsp_zero   <= 1'b0;
      bus.carry_flag <= 1'b0;
    end else begin
      if (accept && is_clc) begin
        bus.carry_flag <= 1'b0;
        bus.rsp_result <= '0;
        bus.rsp_carry  <= 1'b0;
        bus.rsp_zero   <= 1'b1;
        bus.rsp_valid  <= 1'b1;
      end else if (accept) begin
        bus.alu_a1  <= a1_n;
        bus.alu_a2  <= a2_n;
        bus.alu_cin <= cin_n;
        op_q        <= bus.req_op;
        a_q         <= bus.req_a;
        cnt         <= CNT_W'(SETTLE_CYCLES);
      end
      if (state == ST_DRIVE && cnt != '0) cnt <= cnt - 1'b1;
      if (capture) begin
        bus.rsp_result <= op_q == OP_CMP ? a_q : bus.alu_o[7:0];
        bus.rsp_carry  <= bus.alu_o[8];
        bus.rsp_zero   <= bus.alu_o[7:0] == 8'h00;
        bus.carry_flag <= bus.alu_o[8];
        bus.rsp_valid  <= 1'b1;
      end
      if (done) bus.rsp_valid <= 1'b0;
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed tests on two sequencers (settle 1 and 3) sharing one stimulus
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;
  logic clk = 1'b0, rst = 1'b1, sel = 1'b0;
  logic req_valid = 1'b0, rsp_ready = 1'b0;
  logic [2:0] req_op = 3'd0;
  logic [7:0] req_a = 8'd0, req_b = 8'd0;
  int checks = 0, failures = 0;
  alu_op_sequencer_if b1 ();
  alu_op_sequencer_if b3 ();
  alu_op_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  alu_op_sequencer #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
  always #5 clk = ~clk;
  assign b1.alu_o = b1.alu_a1 + b1.alu_a2 + {8'd0, b1.alu_cin};
  assign b3.alu_o = b3.alu_a1 + b3.alu_a2 + {8'd0, b3.alu_cin};
  assign b1.req_valid = req_valid && !sel;
  assign b3.req_valid = req_valid && sel;
  assign b1.req_op = req_op;
  assign b3.req_op = req_op;
  assign b1.req_a = req_a;
  assign b3.req_a = req_a;
  assign b1.req_b = req_b;
  assign b3.req_b = req_b;
  assign b1.rsp_ready = rsp_ready && !sel;
  assign b3.rsp_ready = rsp_ready && sel;
  logic o_req_ready, o_rsp_valid, o_carry, o_zero, o_cf, o_cin;
  logic [7:0] o_result;
  logic [8:0] o_a1, o_a2;
  assign o_req_ready = sel ? b3.req_ready : b1.req_ready;
  assign o_rsp_valid = sel ? b3.rsp_valid : b1.rsp_valid;
  assign o_result = sel ? b3.rsp_result : b1.rsp_result;
  assign o_carry = sel ? b3.rsp_carry : b1.rsp_carry;
  assign o_zero = sel ? b3.rsp_zero : b1.rsp_zero;
  assign o_cf = sel ? b3.carry_flag : b1.carry_flag;
  assign o_a1 = sel ? b3.alu_a1 : b1.alu_a1;
  assign o_a2 = sel ? b3.alu_a2 : b1.alu_a2;
  assign o_cin = sel ? b3.alu_cin : b1.alu_cin;

  // returns at the negedge where rsp_valid is first seen; lat counts edges after the accept edge
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic [8:0] a2s, output logic cins);
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    a2s = o_a2; cins = o_cin;
    while (!o_rsp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++; if (o_req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready sel=%0d got=%b exp=0", s, o_req_ready); end
      checks++; if ({o_rsp_valid, o_result, o_carry, o_zero, o_cf} !== 12'h000) begin failures++; $display("FAIL reset_rsp sel=%0d got=%h exp=000", s, {o_rsp_valid, o_result, o_carry, o_zero, o_cf}); end
      checks++; if ({o_a1, o_a2, o_cin} !== 19'h0) begin failures++; $display("FAIL reset_alu sel=%0d got=%h exp=0", s, {o_a1, o_a2, o_cin}); end
    end
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_req_ready !== 1'b1) begin failures++; $display("FAIL idle_req_ready got=%b exp=1", o_req_ready); end
  endtask

  task automatic test_simple_add;
    int lat; logic [8:0] a2s; logic cins;
    sel = 1'b0;
    issue(OP_ADD, 8'h7F, 8'h01, lat, a2s, cins);
    checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++; if ({o_result, o_carry, o_zero, o_cf} !== {8'h80, 3'b000}) begin failures++; $display("FAIL add_7f_01 got=%h/%b%b%b exp=80/000", o_result, o_carry, o_zero, o_cf); end
    checks++; if (o_req_ready !== 1'b0) begin failures++; $display("FAIL add_resp_req_ready got=%b exp=0", o_req_ready); end
    finish_rsp();
    checks++; if ({o_rsp_valid, o_req_ready} !== 2'b01) begin failures++; $display("FAIL add_handshake got=%b exp=01", {o_rsp_valid, o_req_ready}); end
  endtask

  task automatic test_carry_chain;
    int lat; logic [8:0] a2s; logic cins;
    sel = 1'b0;
    issue(OP_ADD, 8'hFF, 8'h01, lat, a2s, cins);
    checks++; if ({o_result, o_carry, o_zero, o_cf} !== {8'h00, 3'b111}) begin failures++; $display("FAIL add_ff_01 got=%h/%b%b%b exp=00/111", o_result, o_carry, o_zero, o_cf); end
    finish_rsp();
    issue(OP_ADC, 8'h00, 8'h00, lat, a2s, cins);
    checks++; if ({o_result, o_carry, o_zero, o_cf} !== {8'h01, 3'b000}) begin failures++; $display("FAIL adc_carry_in got=%h/%b%b%b exp=01/000", o_result, o_carry, o_zero, o_cf); end
    finish_rsp();
    issue(OP_ADD, 8'hFF, 8'hFF, lat, a2s, cins);
    checks++; if ({o_result, o_carry, o_cf} !== {8'hFE, 2'b11}) begin failures++; $display("FAIL add_ff_ff got=%h/%b%b exp=fe/11", o_result, o_carry, o_cf); end
    finish_rsp();
    issue(OP_CLC, 8'h55, 8'h66, lat, a2s, cins);
    checks++; if (lat !== 0) begin failures++; $display("FAIL clc_latency got=%0d exp=0", lat); end
    checks++; if ({o_result, o_carry, o_zero, o_cf} !== {8'h00, 3'b010}) begin failures++; $display("FAIL clc got=%h/%b%b%b exp=00/010", o_result, o_carry, o_zero, o_cf); end
    checks++; if (o_a2 !== 9'h1FE >> 1) begin failures++; $display("FAIL clc_alu_hold got=%h exp=0ff", o_a2); end
    finish_rsp();
    issue(OP_ADC, 8'h00, 8'h00, lat, a2s, cins);
    checks++; if ({o_result, o_carry, o_zero, o_cf} !== {8'h00, 3'b010}) begin failures++; $display("FAIL adc_after_clc got=%h/%b%b%b exp=00/010", o_result, o_carry, o_zero, o_cf); end
    finish_rsp();
  endtask

  task automatic test_subtract;
    int lat; logic [8:0] a2s; logic cins;
    sel = 1'b0;
    issue(OP_SUB, 8'h07, 8'h05, lat, a2s, cins);
    checks++; if ({a2s, cins} !== {9'h0FA, 1'b1}) begin failures++; $display("FAIL sub_operands got=%h/%b exp=0fa/1", a2s, cins); end
    checks++; if ({o_result, o_carry, o_zero} !== {8'h02, 2'b10}) begin failures++; $display("FAIL sub_no_borrow got=%h/%b%b exp=02/10", o_result, o_carry, o_zero); end
    finish_rsp();
    issue(OP_SUB, 8'h05, 8'h07, lat, a2s, cins);
    checks++; if ({o_result, o_carry, o_cf} !== {8'hFE, 2'b00}) begin failures++; $display("FAIL sub_borrow got=%h/%b%b exp=fe/00", o_result, o_carry, o_cf); end
    finish_rsp();
    issue(OP_SBC, 8'h10, 8'h01, lat, a2s, cins);
    checks++; if ({o_result, o_carry} !== {8'h0E, 1'b1}) begin failures++; $display("FAIL sbc_borrow_in got=%h/%b exp=0e/1", o_result, o_carry); end
    finish_rsp();
    issue(OP_CMP, 8'h05, 8'h05, lat, a2s, cins);
    checks++; if ({o_result, o_carry, o_zero} !== {8'h05, 2'b11}) begin failures++; $display("FAIL cmp_equal got=%h/%b%b exp=05/11", o_result, o_carry, o_zero); end
    finish_rsp();
  endtask

  task automatic test_back_to_back;
    int lat; logic [8:0] a2s; logic cins;
    sel = 1'b1;
    issue(OP_INC, 8'hFF, 8'h00, lat, a2s, cins);
    checks++; if (lat !== 4) begin failures++; $display("FAIL inc_latency got=%0d exp=4", lat); end
    for (int i = 0; i < 5; i++) begin
      checks++; if ({o_rsp_valid, o_result, o_carry, o_zero, o_req_ready} !== {1'b1, 8'h00, 3'b110}) begin failures++; $display("FAIL inc_hold cyc=%0d got=%b/%h/%b%b%b exp=1/00/110", i, o_rsp_valid, o_result, o_carry, o_zero, o_req_ready); end
      @(negedge clk);
    end
    finish_rsp();
    checks++; if ({o_rsp_valid, o_req_ready, o_result, o_carry} !== {2'b01, 8'h00, 1'b1}) begin failures++; $display("FAIL inc_after_handshake got=%b%b/%h/%b exp=01/00/1", o_rsp_valid, o_req_ready, o_result, o_carry); end
    issue(OP_DEC, 8'h00, 8'h00, lat, a2s, cins);
    checks++; if ({a2s, cins} !== {9'h0FF, 1'b0}) begin failures++; $display("FAIL dec_operands got=%h/%b exp=0ff/0", a2s, cins); end
    checks++; if ({o_result, o_carry, o_zero, o_cf} !== {8'hFF, 3'b000}) begin failures++; $display("FAIL dec_00 got=%h/%b%b%b exp=ff/000", o_result, o_carry, o_zero, o_cf); end
    finish_rsp();
  endtask

  task automatic test_async_reset;
    int lat; logic [8:0] a2s; logic cins; logic seen;
    sel = 1'b1;
    issue(OP_ADD, 8'hFF, 8'h01, lat, a2s, cins);
    finish_rsp();
    req_op = OP_ADD; req_a = 8'h10; req_b = 8'h20; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({o_a1, o_a2, o_cin} !== 19'h0) begin failures++; $display("FAIL arst_alu got=%h exp=0", {o_a1, o_a2, o_cin}); end
    checks++; if ({o_rsp_valid, o_result, o_carry, o_zero, o_cf, o_req_ready} !== 13'h0) begin failures++; $display("FAIL arst_outputs got=%h exp=0", {o_rsp_valid, o_result, o_carry, o_zero, o_cf, o_req_ready}); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= o_rsp_valid;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL arst_dropped got=%b exp=0", seen); end
    issue(OP_ADD, 8'h01, 8'h02, lat, a2s, cins);
    checks++; if ({lat[3:0], o_result, o_carry, o_zero} !== {4'd4, 8'h03, 2'b00}) begin failures++; $display("FAIL arst_recover got=%0d/%h/%b%b exp=4/03/00", lat, o_result, o_carry, o_zero); end
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_simple_add();
    test_carry_chain();
    test_subtract();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
